pc_ifetch_master: RTL and testbench
===================================

Name: pc_ifetch_master

Overview:
- Instruction-fetch bus master; reads the instruction stream at the current program counter.
- Sits between the program-counter register and the decode stage.
- Issues Avalon-style word reads to instruction memory, presents each fetched word to decode over a valid/ready handshake, and applies branch/jump redirects with MIPS single delay-slot semantics.
- Stops fetching (halts) when the fetch address becomes 0x00000000.

Parameters:
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset.
- HALT_ADDR, 32'h00000000, fetch address that halts the unit.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- avm_address  out  32  word-aligned read address.
- avm_read  out  1  read request.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  slave stall; read accepted on a cycle with avm_read=1 and avm_waitrequest=0.
- avm_readdata  in  32  read data, valid exactly one cycle after acceptance.
- instr_valid  out  1  instr_data/instr_pc valid.
- instr_ready  in  1  decode accepts; handshake = instr_valid & instr_ready.
- instr_data  out  32  fetched instruction.
- instr_pc  out  32  address instr_data was fetched from.
- redirect_valid  in  1  one-cycle pulse: most recently handshaken instruction is a taken branch/jump.
- redirect_target  in  32  branch/jump target; bits [1:0] ignored (forced 00).
- active  out  1  1 while fetching, 0 once halted.

Behaviour:
- Reset (async, any state, mid-transaction included):
  - State → FETCH, pc = RESET_VECTOR, pending redirect cleared.
  - avm_read=0, avm_address=RESET_VECTOR.
  - instr_valid=0, instr_data=0, instr_pc=0, active=1.
- First avm_read=1 is in the first cycle after rst deasserts.
- FETCH:
  - avm_read=1, avm_address=pc; both held stable while avm_waitrequest=1.
  - On acceptance → CAPTURE.
- CAPTURE:
  - avm_read=0.
  - At the clock edge, instr_data ← avm_readdata, instr_pc ← pc, instr_valid ← 1 → DELIVER.
- DELIVER:
  - instr_valid=1; instr_data and instr_pc held stable until handshake.
  - On the handshake edge: instr_valid ← 0 and pc ← next_pc.
  - If next_pc == HALT_ADDR → HALTED, else → FETCH.
- next_pc selection:
  - If a redirect is pending and the instruction just handshaken is the delay slot (pc == branch_pc+4): next_pc = target; pending cleared.
  - Otherwise: next_pc = pc+4, wrapping modulo 2^32.
- Redirect capture:
  - redirect_valid is accepted from the branch's handshake cycle up to (not including) the next handshake.
  - Unit latches target and branch_pc = instr_pc of the last handshaken instruction.
  - The delay-slot word branch_pc+4 is always fetched and delivered before the target.
- Redirect edge cases:
  - redirect_valid while a redirect is already pending: ignored (first wins).
  - redirect_valid with no prior handshake since reset: ignored.
- HALTED:
  - avm_read=0, instr_valid=0, active=0.
  - Remains until rst; redirect_valid ignored.
- Bus ordering: at most one read outstanding; no prefetch.
- Throughput: minimum 3 cycles per instruction (FETCH, CAPTURE, DELIVER) with zero wait states and instr_ready=1.
- avm_readdata is ignored in all cycles except the one following acceptance.

Test Plan:
- Reset release, waitrequest=0, ready=1, memory returns addr^32'h1234 → avm_read rises cycle 1 at 0xBFC00000; deliveries at 0xBFC00000, 0xBFC00004, 0xBFC00008, one per 3 cycles, instr_data matching.
- avm_waitrequest=1 for 5 cycles on first fetch → avm_read and avm_address=0xBFC00000 held 5 cycles; single read issued; data delivered once.
- instr_ready=0 for 4 cycles in DELIVER → instr_valid held; instr_data/instr_pc stable; no new avm_read until handshake.
- Handshake at 0xBFC00010 with redirect_valid=1, target=0xBFC00100 → next deliveries 0xBFC00014 then 0xBFC00100, 0xBFC00104; second redirect (target 0x0) during delay-slot fetch ignored.
- Redirect to target 0x00000000 → delay slot delivered; unit enters HALTED; active=0; no further avm_read.
- rst asserted while avm_read=1 and waitrequest=1 → outputs immediately at reset values; after release, fetch restarts at 0xBFC00000 with no pending redirect.

Source files
------------

// File: rtl/pc_ifetch_if.sv
// Bus bundle for the instruction-fetch master: Avalon-style read port,
// decode-side valid/ready handshake and redirect input.
interface pc_ifetch_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        active;

    modport master (
        output avm_address, avm_read, avm_byteenable,
        input  avm_waitrequest, avm_readdata,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_target,
        output active
    );

    modport slave (
        input  avm_address, avm_read, avm_byteenable,
        output avm_waitrequest, avm_readdata,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_target,
        input  active
    );
endinterface

// File: rtl/pc_ifetch_master.sv
// Instruction-fetch bus master: one word read at a time from the PC, hands each
// word to decode, and applies branch redirects after a single delay slot.
module pc_ifetch_master #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    pc_ifetch_if.master   bus
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DELIVER = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    state_t      state_r;
    logic [31:0] pc_r;
    logic        avm_read_r;
    logic [31:0] avm_address_r;
    logic        instr_valid_r;
    logic [31:0] instr_data_r;
    logic [31:0] instr_pc_r;
    logic        active_r;

    logic        pend_r;
    logic [31:0] branch_pc_r;
    logic [31:0] target_r;
    logic        seen_hs_r;
    logic [31:0] last_hs_pc_r;

    logic        hs_s;
    logic        acc_s;
    logic        consume_s;
    logic        take_s;
    logic [31:0] next_pc_s;
    logic [31:0] redirect_branch_s;

    // Handshake/acceptance decode, next-PC selection and redirect qualification
    always_comb begin
        hs_s              = 1'b0;
        acc_s             = 1'b0;
        consume_s         = 1'b0;
        take_s            = 1'b0;
        next_pc_s         = 32'd0;
        redirect_branch_s = 32'd0;

        hs_s      = (state_r == ST_DELIVER) && instr_valid_r && bus.instr_ready;
        acc_s     = (state_r == ST_FETCH) && avm_read_r && !bus.avm_waitrequest;
        // The redirect only takes effect once its delay slot has been handed over.
        consume_s = pend_r && hs_s && (pc_r == branch_pc_r + 32'd4);

        if (consume_s) begin
            next_pc_s = target_r;
        end else begin
            next_pc_s = pc_r + 32'd4;
        end

        take_s = bus.redirect_valid && !pend_r && (state_r != ST_HALTED)
                 && (hs_s || seen_hs_r);

        // A redirect in the handshake cycle belongs to the word being handed over now.
        if (hs_s) begin
            redirect_branch_s = instr_pc_r;
        end else begin
            redirect_branch_s = last_hs_pc_r;
        end
    end

    // Fetch sequencer with registered bus and decode-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_VECTOR;
            avm_read_r    <= 1'b0;
            avm_address_r <= RESET_VECTOR;
            instr_valid_r <= 1'b0;
            instr_data_r  <= 32'd0;
            instr_pc_r    <= 32'd0;
            active_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (!avm_read_r) begin
                        avm_read_r    <= 1'b1;
                        avm_address_r <= pc_r;
                    end else if (acc_s) begin
                        avm_read_r <= 1'b0;
                        state_r    <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    instr_data_r  <= bus.avm_readdata;
                    instr_pc_r    <= pc_r;
                    instr_valid_r <= 1'b1;
                    state_r       <= ST_DELIVER;
                end
                ST_DELIVER: begin
                    if (hs_s) begin
                        instr_valid_r <= 1'b0;
                        pc_r          <= next_pc_s;
                        if (next_pc_s == HALT_ADDR) begin
                            state_r  <= ST_HALTED;
                            active_r <= 1'b0;
                        end else begin
                            // Issue the next read on this edge to keep 3 cycles per word.
                            state_r       <= ST_FETCH;
                            avm_read_r    <= 1'b1;
                            avm_address_r <= next_pc_s;
                        end
                    end
                end
                ST_HALTED: begin
                    avm_read_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                    active_r      <= 1'b0;
                end
                default: begin
                    state_r       <= ST_HALTED;
                    avm_read_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                    active_r      <= 1'b0;
                end
            endcase
        end
    end

    // Pending-redirect bookkeeping; the first redirect wins until it is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r       <= 1'b0;
            branch_pc_r  <= 32'd0;
            target_r     <= 32'd0;
            seen_hs_r    <= 1'b0;
            last_hs_pc_r <= 32'd0;
        end else begin
            if (take_s) begin
                pend_r      <= 1'b1;
                target_r    <= word_align(bus.redirect_target);
                branch_pc_r <= redirect_branch_s;
            end else if (consume_s) begin
                pend_r <= 1'b0;
            end
            if (hs_s) begin
                seen_hs_r    <= 1'b1;
                last_hs_pc_r <= instr_pc_r;
            end
        end
    end

    assign bus.avm_address    = avm_address_r;
    assign bus.avm_read       = avm_read_r;
    assign bus.avm_byteenable = 4'hF;
    assign bus.instr_valid    = instr_valid_r;
    assign bus.instr_data     = instr_data_r;
    assign bus.instr_pc       = instr_pc_r;
    assign bus.active         = active_r;

endmodule

// File: tb/tb_pc_ifetch_master.sv
// Self-checking bench for pc_ifetch_master: directed scenarios plus a random
// run, checked against a PC-sequence reference model of the fetch stream.
module tb_pc_ifetch_master;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_ifetch_if bus ();
    pc_ifetch_master dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passes = 0;
    int cyc_n  = 0;
    int n_acc  = 0;
    logic [31:0] key;

    // Reference model: next PC to deliver and the pending delay-slot redirect
    logic [31:0] m_pc, m_bpc, m_tgt, m_last;
    bit          m_pend, m_seen, m_halted;
    bit          outstanding, acc_prev;
    logic [31:0] acc_addr;
    bit          prev_stall_rd, prev_stall_iv;
    logic [31:0] prev_addr, prev_d, prev_p;
    logic [31:0] dq[$];
    int          hs_cyc[$];

    logic        o_read, o_valid, o_active;
    logic [31:0] o_addr, o_data, o_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic model_reset();
        m_pc = RV; m_pend = 1'b0; m_seen = 1'b0; m_halted = 1'b0;
        m_bpc = 32'd0; m_tgt = 32'd0; m_last = 32'd0;
        outstanding = 1'b0; acc_prev = 1'b0;
        prev_stall_rd = 1'b0; prev_stall_iv = 1'b0;
        dq.delete(); hs_cyc.delete();
        cyc_n = 0; n_acc = 0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_read",   32'(bus.avm_read),       32'd0);
        chk("rst_addr",   bus.avm_address,         RV);
        chk("rst_valid",  32'(bus.instr_valid),    32'd0);
        chk("rst_data",   bus.instr_data,          32'd0);
        chk("rst_pc",     bus.instr_pc,            32'd0);
        chk("rst_active", 32'(bus.active),         32'd1);
        chk("rst_be",     32'(bus.avm_byteenable), 32'hF);
    endtask

    task automatic do_reset(input logic [31:0] k);
        @(negedge clk);
        rst = 1'b1;
        key = k;
        bus.avm_waitrequest = 1'b0; bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;  bus.redirect_target = 32'd0;
        bus.avm_readdata = $urandom;
        #1;
        chk_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: sample outputs, drive inputs, check against the model
    task automatic cyc(input bit wr, input bit rdy, input bit rv, input logic [31:0] rt);
        bit acc, hs, take, consume;
        logic [31:0] nxt, bpc_new;
        @(negedge clk);
        cyc_n++;
        o_read = bus.avm_read;   o_addr = bus.avm_address; o_valid = bus.instr_valid;
        o_data = bus.instr_data; o_pc = bus.instr_pc;      o_active = bus.active;
        bus.avm_waitrequest = wr; bus.instr_ready = rdy;
        bus.redirect_valid = rv;  bus.redirect_target = rt;
        bus.avm_readdata = acc_prev ? mem(acc_addr) : $urandom;
        acc = o_read && !wr;
        hs  = o_valid && rdy;

        if (m_halted) begin
            chk("halt_read",   32'(o_read),   32'd0);
            chk("halt_valid",  32'(o_valid),  32'd0);
            chk("halt_active", 32'(o_active), 32'd0);
        end
        if (prev_stall_rd) begin
            chk("read_hold", 32'(o_read), 32'd1);
            chk("addr_hold", o_addr, prev_addr);
        end
        if (prev_stall_iv) begin
            chk("valid_hold", 32'(o_valid), 32'd1);
            chk("data_hold",  o_data, prev_d);
            chk("pc_hold",    o_pc, prev_p);
        end
        if (acc) begin
            chk("one_outstanding", 32'(outstanding), 32'd0);
            chk("fetch_addr", o_addr, m_pc);
            outstanding = 1'b1;
            acc_addr = o_addr;
            n_acc++;
        end

        consume = 1'b0;
        nxt = m_pc + 32'd4;
        if (hs) begin
            chk("hs_pc", o_pc, m_pc);
            chk("hs_data", o_data, mem(m_pc));
            dq.push_back(o_pc);
            hs_cyc.push_back(cyc_n);
            outstanding = 1'b0;
            if (m_pend && m_pc == m_bpc + 32'd4) begin
                consume = 1'b1;
                nxt = m_tgt;
            end
        end
        take = rv && !m_pend && !m_halted && (hs || m_seen);
        bpc_new = hs ? m_pc : m_last;
        if (hs) begin
            m_last = m_pc; m_seen = 1'b1;
            if (consume) m_pend = 1'b0;
            m_pc = nxt;
            if (nxt == 32'd0) m_halted = 1'b1;
        end
        if (take) begin
            m_pend = 1'b1; m_tgt = {rt[31:2], 2'b00}; m_bpc = bpc_new;
        end

        acc_prev = acc;
        prev_stall_rd = o_read && wr;  prev_addr = o_addr;
        prev_stall_iv = o_valid && !rdy; prev_d = o_data; prev_p = o_pc;
    endtask

    initial begin
        bus.avm_waitrequest = 1'b0; bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;  bus.redirect_target = 32'd0;
        bus.avm_readdata = 32'd0;
        key = 32'h1234;
        model_reset();

        // Back-to-back fetches with no stalls
        do_reset(32'h1234);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk("first_read", 32'(o_read), 32'd1);
        chk("first_addr", o_addr, RV);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk("p1_count", 32'(dq.size()), 32'd3);
        if (dq.size() == 3) begin
            chk("p1_pc0", dq[0], RV);
            chk("p1_pc1", dq[1], RV + 32'd4);
            chk("p1_pc2", dq[2], RV + 32'd8);
            chk("p1_first_cyc", 32'(hs_cyc[0]), 32'd3);
            chk("p1_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
            chk("p1_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
        end

        // Waitrequest on the first fetch, then decode back-pressure
        do_reset($urandom);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'd0);
            chk("wait_read", 32'(o_read), 32'd1);
            chk("wait_addr", o_addr, RV);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk("wait_acc", 32'(n_acc), 32'd1);
        chk("wait_deliv", 32'(dq.size()), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'd0);
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_pc", o_pc, RV + 32'd4);
            chk("bp_no_read", 32'(n_acc), 32'd2);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk("bp_deliv", 32'(dq.size()), 32'd2);

        // Redirect with delay slot, ignored second redirect, then redirect to halt
        do_reset(32'h1234);
        for (int i = 1; i <= 35; i++) begin
            if (i == 15)                 cyc(1'b0, 1'b1, 1'b1, 32'hBFC0_0101);
            else if (i == 16 || i == 17) cyc(1'b0, 1'b1, 1'b1, 32'h0000_0000);
            else if (i == 25)            cyc(1'b0, 1'b1, 1'b1, 32'h0000_0000);
            else                         cyc(1'b0, 1'b1, 1'b0, 32'd0);
        end
        chk("rd_count", 32'(dq.size()), 32'd9);
        if (dq.size() == 9) begin
            chk("rd_slot",  dq[5], RV + 32'h14);
            chk("rd_tgt0",  dq[6], RV + 32'h100);
            chk("rd_tgt1",  dq[7], RV + 32'h104);
            chk("rd_halt_slot", dq[8], RV + 32'h108);
        end
        chk("rd_active", 32'(o_active), 32'd0);
        chk("rd_read",   32'(o_read),   32'd0);
        chk("rd_acc",    32'(n_acc),    32'd9);

        // Reset during a stalled read with a redirect pending
        do_reset($urandom);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 32'h8000_0000);
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        chk("mid_read_before", 32'(o_read), 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk("mid_count", 32'(dq.size()), 32'd4);
        if (dq.size() == 4) begin
            chk("mid_pc0", dq[0], RV);
            chk("mid_pc2", dq[2], RV + 32'd8);
            chk("mid_pc3", dq[3], RV + 32'hC);
        end

        // Randomised traffic, including wrap-to-zero halts
        do_reset($urandom);
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rt;
            int sel;
            sel = int'($urandom_range(15, 0));
            if (sel == 0)      rt = 32'h0000_0000;
            else if (sel == 1) rt = 32'hFFFF_FFF0 | 32'($urandom_range(3, 0));
            else               rt = {RV[31:12], 12'($urandom)};
            cyc(($urandom % 4) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0, rt);
            if (m_halted && ($urandom % 4) == 0) do_reset($urandom);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
